// File: rtl/prim_cipher_pkg.sv
// PRESENT primitives shared by the iterative cipher: sbox tables, bit permutations,
// forward/inverse key schedules, FSM state type and round-count limit.
package prim_cipher_pkg;

    typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} prim_present_iter_state_e;

    localparam int PRESENT_MAX_ROUNDS = 31;

    localparam logic [15:0][3:0] PRESENT_SBOX4 = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC};

    localparam logic [15:0][3:0] PRESENT_SBOX4_INV = {
        4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
        4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5};

    // Bit i moves to i*W/4 mod (W-1); the MSB stays put.
    function automatic logic [63:0] perm64(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        y     = '0;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            if (inv) y[i] = x[6'((i * 16) % 63)];
            else     y[6'((i * 16) % 63)] = x[i];
        end
        return y;
    endfunction

    function automatic logic [31:0] perm32(input logic [31:0] x, input logic inv);
        logic [31:0] y;
        y     = '0;
        y[31] = x[31];
        for (int i = 0; i < 31; i++) begin
            if (inv) y[i] = x[5'((i * 8) % 31)];
            else     y[5'((i * 8) % 31)] = x[i];
        end
        return y;
    endfunction

    // Forward updates rotate left by 61; the inverse rotates left by W-61.
    function automatic logic [63:0] key64_fwd(input logic [63:0] k, input logic [4:0] idx);
        logic [63:0] y;
        y        = {k[2:0], k[63:3]};
        y[63:60] = PRESENT_SBOX4[y[63:60]];
        y[19:15] = y[19:15] ^ idx;
        return y;
    endfunction

    function automatic logic [63:0] key64_inv(input logic [63:0] k, input logic [4:0] idx);
        logic [63:0] y;
        y        = k;
        y[19:15] = y[19:15] ^ idx;
        y[63:60] = PRESENT_SBOX4_INV[y[63:60]];
        return {y[60:0], y[63:61]};
    endfunction

    function automatic logic [79:0] key80_fwd(input logic [79:0] k, input logic [4:0] idx);
        logic [79:0] y;
        y        = {k[18:0], k[79:19]};
        y[79:76] = PRESENT_SBOX4[y[79:76]];
        y[19:15] = y[19:15] ^ idx;
        return y;
    endfunction

    function automatic logic [79:0] key80_inv(input logic [79:0] k, input logic [4:0] idx);
        logic [79:0] y;
        y        = k;
        y[19:15] = y[19:15] ^ idx;
        y[79:76] = PRESENT_SBOX4_INV[y[79:76]];
        return {y[60:0], y[79:61]};
    endfunction

    function automatic logic [127:0] key128_fwd(input logic [127:0] k, input logic [4:0] idx);
        logic [127:0] y;
        y          = {k[66:0], k[127:67]};
        y[127:124] = PRESENT_SBOX4[y[127:124]];
        y[123:120] = PRESENT_SBOX4[y[123:120]];
        y[66:62]   = y[66:62] ^ idx;
        return y;
    endfunction

    function automatic logic [127:0] key128_inv(input logic [127:0] k, input logic [4:0] idx);
        logic [127:0] y;
        y          = k;
        y[66:62]   = y[66:62] ^ idx;
        y[127:124] = PRESENT_SBOX4_INV[y[127:124]];
        y[123:120] = PRESENT_SBOX4_INV[y[123:120]];
        return {y[60:0], y[127:61]};
    endfunction

endpackage

// File: rtl/prim_present_round.sv
// Combinational slice of NumPhysRounds PRESENT rounds; key_only advances just the key
// schedule and passes the data through untouched.
module prim_present_round
    import prim_cipher_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int KeyWidth      = 128,
    parameter int NumPhysRounds = 1
) (
    input  logic [DataWidth-1:0] i_data,
    input  logic [KeyWidth-1:0]  i_key,
    input  logic [4:0]           i_idx,
    input  logic                 i_dec_mode,
    input  logic                 i_key_only,
    output logic [DataWidth-1:0] o_data,
    output logic [KeyWidth-1:0]  o_key,
    output logic [4:0]           o_idx
);

    logic [NumPhysRounds:0][DataWidth-1:0] w_data;
    logic [NumPhysRounds:0][KeyWidth-1:0]  w_key;
    logic [NumPhysRounds:0][4:0]           w_idx;

    assign w_data[0] = i_data;
    assign w_key[0]  = i_key;
    assign w_idx[0]  = i_idx;

    for (genvar k = 0; k < NumPhysRounds; k++) begin : g_rnd
        logic [DataWidth-1:0] w_ak, w_sb, w_enc, w_ip, w_dec;
        logic [KeyWidth-1:0]  w_kf, w_ki;

        assign w_ak = w_data[k] ^ w_key[k][KeyWidth-1 -: DataWidth];

        for (genvar n = 0; n < DataWidth / 4; n++) begin : g_nib
            assign w_sb[4*n +: 4]  = PRESENT_SBOX4[w_ak[4*n +: 4]];
            assign w_dec[4*n +: 4] = PRESENT_SBOX4_INV[w_ip[4*n +: 4]];
        end

        if (DataWidth == 64) begin : g_p64
            assign w_enc = perm64(w_sb, 1'b0);
            assign w_ip  = perm64(w_ak, 1'b1);
        end else begin : g_p32
            assign w_enc = perm32(w_sb, 1'b0);
            assign w_ip  = perm32(w_ak, 1'b1);
        end

        if (KeyWidth == 128) begin : g_k128
            assign w_kf = key128_fwd(w_key[k], w_idx[k]);
            assign w_ki = key128_inv(w_key[k], w_idx[k]);
        end else if (KeyWidth == 80) begin : g_k80
            assign w_kf = key80_fwd(w_key[k], w_idx[k]);
            assign w_ki = key80_inv(w_key[k], w_idx[k]);
        end else begin : g_k64
            assign w_kf = key64_fwd(w_key[k], w_idx[k]);
            assign w_ki = key64_inv(w_key[k], w_idx[k]);
        end

        assign w_data[k+1] = i_key_only ? w_data[k] : (i_dec_mode ? w_dec : w_enc);
        assign w_key[k+1]  = i_dec_mode ? w_ki : w_kf;
        assign w_idx[k+1]  = i_dec_mode ? w_idx[k] - 5'd1 : w_idx[k] + 5'd1;
    end

    assign o_data = w_data[NumPhysRounds];
    assign o_key  = w_key[NumPhysRounds];
    assign o_idx  = w_idx[NumPhysRounds];

endmodule

// File: rtl/prim_present_iter.sv
// Iterative ready/valid PRESENT engine. Define PRIM_PRESENT_ITER_KEY_CACHE_EN to keep the
// last derived decrypt key so repeated decrypts with the same user key skip key expansion.
module prim_present_iter
    import prim_cipher_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int KeyWidth      = 128,
    parameter int NumRounds     = 31,
    parameter int NumPhysRounds = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 decrypt_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [KeyWidth-1:0]  key_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] data_o
);

    localparam int N    = NumRounds / NumPhysRounds;
    localparam int CntW = $clog2(N + 1);

    prim_present_iter_state_e r_state;
    logic [DataWidth-1:0]     r_data;
    logic [KeyWidth-1:0]      r_key;
    logic [4:0]               r_idx;
    logic                     r_dec;
    logic [CntW-1:0]          r_cnt;
    logic                     r_out_valid;

    logic [DataWidth-1:0] w_data_nxt;
    logic [KeyWidth-1:0]  w_key_nxt;
    logic [4:0]           w_idx_nxt;
    logic                 w_in_hs, w_last;

`ifdef PRIM_PRESENT_ITER_KEY_CACHE_EN
    logic                r_cache_vld;
    logic [KeyWidth-1:0] r_cache_ukey, r_cache_dkey, r_ukey;
`endif

    assign in_ready_o  = (r_state == IDLE) | ((r_state == DONE) & out_ready_i);
    assign out_valid_o = r_out_valid;
    assign data_o      = r_data;
    assign w_in_hs     = in_valid_i & in_ready_o;
    assign w_last      = (r_cnt == CntW'(N - 1));

    // Key expansion always runs the schedule forward, whatever the request direction.
    prim_present_round #(
        .DataWidth     (DataWidth),
        .KeyWidth      (KeyWidth),
        .NumPhysRounds (NumPhysRounds)
    ) u_round (
        .i_data     (r_data),
        .i_key      (r_key),
        .i_idx      (r_idx),
        .i_dec_mode (r_dec & (r_state == RUN)),
        .i_key_only (r_state == KEYEXP),
        .o_data     (w_data_nxt),
        .o_key      (w_key_nxt),
        .o_idx      (w_idx_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_key       <= '0;
            r_idx       <= '0;
            r_dec       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef PRIM_PRESENT_ITER_KEY_CACHE_EN
            r_cache_vld  <= 1'b0;
            r_cache_ukey <= '0;
            r_cache_dkey <= '0;
            r_ukey       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (r_state == DONE && out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                    if (w_in_hs) begin
                        r_data  <= data_i;
                        r_key   <= key_i;
                        r_dec   <= decrypt_i;
                        r_idx   <= 5'd1;
                        r_cnt   <= '0;
                        r_state <= decrypt_i ? KEYEXP : RUN;
`ifdef PRIM_PRESENT_ITER_KEY_CACHE_EN
                        r_ukey <= key_i;
                        if (decrypt_i && r_cache_vld && key_i == r_cache_ukey) begin
                            r_key   <= r_cache_dkey;
                            r_idx   <= 5'(NumRounds);
                            r_state <= RUN;
                        end
`endif
                    end
                end
                KEYEXP: begin
                    r_key <= w_key_nxt;
                    r_idx <= w_idx_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_idx   <= 5'(NumRounds);
                        r_cnt   <= '0;
                        r_state <= RUN;
`ifdef PRIM_PRESENT_ITER_KEY_CACHE_EN
                        r_cache_vld  <= 1'b1;
                        r_cache_ukey <= r_ukey;
                        r_cache_dkey <= w_key_nxt;
`endif
                    end
                end
                RUN: begin
                    r_data <= w_data_nxt;
                    r_key  <= w_key_nxt;
                    r_idx  <= w_idx_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_data      <= w_data_nxt ^ w_key_nxt[KeyWidth-1 -: DataWidth];
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prim_present_iter.sv
// Directed known-answer, handshake and reset checks on a 64/80 single-round engine, plus
// enc->dec round trips on fully unrolled 64/128 and 32/64 engines.
module tb_prim_present_iter;

`ifdef PRIM_PRESENT_ITER_KEY_CACHE_EN
    localparam int LAT_HIT = 31;
`else
    localparam int LAT_HIT = 62;
`endif

    localparam logic [79:0] K_ONES  = {80{1'b1}};
    localparam logic [63:0] D_ONES  = {64{1'b1}};
    localparam logic [63:0] CT_0_0  = 64'h5579C1387B228445;
    localparam logic [63:0] CT_0_1  = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_1_0  = 64'hA112FFC72F68417B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_iv = 0, a_dec = 0, a_ordy = 0, a_irdy, a_ov;
    logic [63:0] a_din = '0, a_dout;
    logic [79:0] a_key = '0;

    logic         b_iv = 0, b_dec = 0, b_ordy = 0, b_irdy, b_ov;
    logic [63:0]  b_din = '0, b_dout;
    logic [127:0] b_key = '0;

    logic        c_iv = 0, c_dec = 0, c_ordy = 0, c_irdy, c_ov;
    logic [31:0] c_din = '0, c_dout;
    logic [63:0] c_key = '0;

    int n_chk = 0;
    int n_fail = 0;

    prim_present_iter #(.DataWidth(64), .KeyWidth(80), .NumRounds(31), .NumPhysRounds(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_irdy), .decrypt_i(a_dec),
        .data_i(a_din), .key_i(a_key), .out_valid_o(a_ov), .out_ready_i(a_ordy), .data_o(a_dout));

    prim_present_iter #(.DataWidth(64), .KeyWidth(128), .NumRounds(31), .NumPhysRounds(31)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_irdy), .decrypt_i(b_dec),
        .data_i(b_din), .key_i(b_key), .out_valid_o(b_ov), .out_ready_i(b_ordy), .data_o(b_dout));

    prim_present_iter #(.DataWidth(32), .KeyWidth(64), .NumRounds(31), .NumPhysRounds(31)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(c_iv), .in_ready_o(c_irdy), .decrypt_i(c_dec),
        .data_i(c_din), .key_i(c_key), .out_valid_o(c_ov), .out_ready_i(c_ordy), .data_o(c_dout));

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic a_send(input logic dec, input logic [63:0] d, input logic [79:0] k);
        a_iv = 1'b1; a_dec = dec; a_din = d; a_key = k;
        #1 chk("a_in_ready", a_irdy, 1);
        @(posedge clk);
        @(negedge clk);
        a_iv = 1'b0;
    endtask

    task automatic a_wait(output int lat);
        lat = 0;
        while (!a_ov && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic a_take();
        a_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_ordy = 1'b0;
        chk("a_ov_drop", a_ov, 0);
    endtask

    task automatic a_op(input string tag, input logic dec, input logic [63:0] d,
                        input logic [79:0] k, input logic [63:0] exp, input int exp_lat);
        int lat;
        a_send(dec, d, k);
        a_wait(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, a_dout, exp);
        a_take();
    endtask

    task automatic b_op(input logic dec, input logic [63:0] d, input logic [127:0] k,
                        output logic [63:0] r, output int lat);
        b_iv = 1'b1; b_dec = dec; b_din = d; b_key = k;
        @(posedge clk);
        @(negedge clk);
        b_iv = 1'b0;
        lat = 0;
        while (!b_ov && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = b_dout;
        b_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ordy = 1'b0;
    endtask

    task automatic c_op(input logic dec, input logic [31:0] d, input logic [63:0] k,
                        output logic [31:0] r, output int lat);
        c_iv = 1'b1; c_dec = dec; c_din = d; c_key = k;
        @(posedge clk);
        @(negedge clk);
        c_iv = 1'b0;
        lat = 0;
        while (!c_ov && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = c_dout;
        c_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_ordy = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0]  pt, ct, rt;
        logic [127:0] kb;
        logic [31:0]  pc, cc, rc;
        logic [63:0]  kc;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", a_irdy, 1);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_data", a_dout, 0);
        rst = 1'b0;
        @(negedge clk);

        a_op("t1_enc", 0, 64'h0, 80'h0, CT_0_0, 31);
        a_op("t2_enc", 0, 64'h0, K_ONES, CT_0_1, 31);
        a_op("t2_dec", 1, CT_0_1, K_ONES, 64'h0, 62);
        a_op("t2_dec_again", 1, CT_0_1, K_ONES, 64'h0, LAT_HIT);

        a_send(0, D_ONES, 80'h0);
        a_wait(lat);
        chk("t3_lat", lat, 31);
        chk("t3_data", a_dout, CT_1_0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_data", a_dout, CT_1_0);
            chk("t3_hold_valid", a_ov, 1);
            chk("t3_hold_in_ready", a_irdy, 0);
        end
        a_take();

        a_send(0, 64'h0, 80'h0);
        a_wait(lat);
        chk("t4_first", a_dout, CT_0_0);
        a_ordy = 1'b1;
        a_iv = 1'b1; a_dec = 1'b0; a_din = D_ONES; a_key = 80'h0;
        #1 chk("t4_in_ready_done", a_irdy, 1);
        @(posedge clk);
        @(negedge clk);
        a_iv = 1'b0; a_ordy = 1'b0;
        chk("t4_ov_after_b2b", a_ov, 0);
        a_wait(lat);
        chk("t4_second_lat", lat, 31);
        chk("t4_second_data", a_dout, CT_1_0);
        a_take();

        a_send(1, CT_0_1, K_ONES);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_in_ready", a_irdy, 1);
        chk("t5_out_valid", a_ov, 0);
        chk("t5_data", a_dout, 0);
        a_op("t5_enc", 0, 64'h0, 80'h0, CT_0_0, 31);
        a_op("t5_dec_cold", 1, CT_0_1, K_ONES, 64'h0, 62);

        b_op(0, 64'h0, 128'h0, rt, lat);
        chk("t6_b_kat", rt, 64'h96DB702A2E6900AF);
        chk("t6_b_kat_lat", lat, 1);
        for (int i = 0; i < 1000; i++) begin
            pt = {$urandom, $urandom};
            kb = {$urandom, $urandom, $urandom, $urandom};
            b_op(0, pt, kb, ct, lat);
            b_op(1, ct, kb, rt, lat);
            chk("t6_b_rt", rt, pt);
            chk("t6_b_rt_lat", lat, 2);
        end
        for (int i = 0; i < 1000; i++) begin
            pc = $urandom;
            kc = {$urandom, $urandom};
            c_op(0, pc, kc, cc, lat);
            c_op(1, cc, kc, rc, lat);
            chk("t6_c_rt", rc, pc);
            chk("t6_c_rt_lat", lat, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
